// File: rtl/data_memory_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl_if
// CPU <-> data memory request bus.
//   read, write   : load / store request, held by the CPU until busy_wait falls
//   address       : word address of the request
//   writedata     : store data
//   readdata      : registered load result
//   busy_wait     : stall back to the CPU / register file
// Modports: master = CPU side, slave = memory controller side.
// -----------------------------------------------------------------------------
interface data_memory_ctrl_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  read;
   logic                  write;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;
   logic                  busy_wait;

   modport master (
      output read, write, address, writedata,
      input  readdata, busy_wait
   );

   modport slave (
      input  read, write, address, writedata,
      output readdata, busy_wait
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
// Multi-cycle data memory answering CPU load/store requests. A request is
// sampled in IDLE, takes LATENCY cycles in ACCESS, then passes through a
// one-cycle DONE state so a request still held by the CPU is not re-issued.
// Ports:
//   CLK    : system clock, all state changes on posedge
//   RESET  : asynchronous, active-high; clears state, counter, readdata,
//            latched request and every memory word
//   bus    : data_memory_ctrl_if.slave (read, write, address, writedata in;
//            readdata, busy_wait out)
// LATENCY must lie in 1..15 (4-bit down-counter).
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int LATENCY    = 4
) (
   input  logic                CLK,
   input  logic                RESET,
   data_memory_ctrl_if.slave   bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                state_reg;
   logic [3:0]            counter_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [DATA_WIDTH-1:0] data_reg;
   logic                  op_write_reg;
   logic [DATA_WIDTH-1:0] readdata_reg;
   logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg    <= IDLE;
         counter_reg  <= '0;
         addr_reg     <= '0;
         data_reg     <= '0;
         op_write_reg <= 1'b0;
         readdata_reg <= '0;
         // Memory contents are cleared on reset, so this array lives in
         // fabric registers rather than block RAM.
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.read || bus.write) begin
                  addr_reg     <= bus.address;
                  data_reg     <= bus.writedata;
                  // Write takes priority when both requests are raised.
                  op_write_reg <= bus.write;
                  counter_reg  <= 4'(LATENCY - 1);
                  state_reg    <= ACCESS;
               end
            end
            ACCESS: begin
               if (counter_reg != 4'd0) begin
                  counter_reg <= counter_reg - 4'd1;
               end else begin
                  if (op_write_reg) begin
                     mem_reg[addr_reg] <= data_reg;
                  end else begin
                     readdata_reg <= mem_reg[addr_reg];
                  end
                  state_reg <= DONE;
               end
            end
            DONE: begin
               // Request is deliberately not sampled here: the CPU may still
               // be holding it during this cycle.
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Combinational so the stall reaches the CPU in the same cycle the
   // request appears; falls on the edge that enters DONE.
   assign bus.busy_wait = ((state_reg == IDLE) && (bus.read || bus.write)) ||
                          (state_reg == ACCESS);
   assign bus.readdata  = readdata_reg;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed testbench with scoreboard queues: stimulus pushes the expected
// busy pulse length and readdata for each request, a monitor per DUT pops and
// compares when busy_wait falls.
module tb_data_memory_ctrl;
   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   data_memory_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if4 ();
   data_memory_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if1 ();

   data_memory_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(4)) dut4 (
      .CLK(CLK), .RESET(RESET), .bus(if4.slave));
   data_memory_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(1)) dut1 (
      .CLK(CLK), .RESET(RESET), .bus(if1.slave));

   typedef struct {
      logic [7:0] rd;
      int         len;
      string      name;
   } exp_t;

   exp_t q4[$];
   exp_t q1[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // ---------------- monitors ----------------
   logic prev4 = 1'b0, prev1 = 1'b0;
   int   len4 = 0, len1 = 0;

   always @(negedge CLK) begin
      exp_t e;
      if (if4.busy_wait) begin
         if (!prev4) begin
            len4 = 0;
            if (q4.size() == 0) check("L4 unexpected_busy_pulse", 1, 0);
         end
         len4++;
      end else if (prev4 && q4.size() != 0) begin
         e = q4.pop_front();
         check({"L4 ", e.name, " busy_len"}, len4, e.len);
         check({"L4 ", e.name, " readdata"}, int'(if4.readdata), int'(e.rd));
      end
      prev4 = if4.busy_wait;
   end

   always @(negedge CLK) begin
      exp_t e;
      if (if1.busy_wait) begin
         if (!prev1) begin
            len1 = 0;
            if (q1.size() == 0) check("L1 unexpected_busy_pulse", 1, 0);
         end
         len1++;
      end else if (prev1 && q1.size() != 0) begin
         e = q1.pop_front();
         check({"L1 ", e.name, " busy_len"}, len1, e.len);
         check({"L1 ", e.name, " readdata"}, int'(if1.readdata), int'(e.rd));
      end
      prev1 = if1.busy_wait;
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input int d, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] wd);
      if (d == 0) begin
         if4.read = rd; if4.write = wr; if4.address = a; if4.writedata = wd;
      end else begin
         if1.read = rd; if1.write = wr; if1.address = a; if1.writedata = wd;
      end
   endtask

   function automatic logic busy(input int d);
      return (d == 0) ? if4.busy_wait : if1.busy_wait;
   endfunction

   task automatic push(input int d, input logic [7:0] rd, input int len, input string name);
      exp_t e;
      e.rd = rd; e.len = len; e.name = name;
      if (d == 0) q4.push_back(e);
      else        q1.push_back(e);
   endtask

   // Returns at the negedge where busy_wait is low (DONE state).
   task automatic wait_done(input int d, input string name);
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (busy(d) && n < 40);
      if (busy(d)) check({name, " timeout_busy_stuck"}, 1, 0);
   endtask

   task automatic access(input int d, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] exp_rd, input int exp_len,
                         input string name, input bit hold);
      @(negedge CLK); #1;
      push(d, exp_rd, exp_len, name);
      drive(d, rd, wr, a, wd);
      wait_done(d, name);
      // Optionally keep the request raised across the DONE->IDLE edge.
      if (hold) begin
         @(posedge CLK); #1;
      end else begin
         #1;
      end
      drive(d, 1'b0, 1'b0, a, wd);
      repeat (2) @(negedge CLK);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 8'h00, 8'h00);

      // Reset held for two cycles, no request.
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         check("reset busy_wait L4", int'(if4.busy_wait), 0);
         check("reset readdata L4",  int'(if4.readdata),  0);
         check("reset busy_wait L1", int'(if1.busy_wait), 0);
      end
      #1 RESET = 1'b0;

      access(0, 1, 0, 8'h10, 8'h00, 8'h00, 4, "read_0x10_after_reset", 0);
      access(0, 0, 1, 8'h02, 8'hC8, 8'h00, 4, "write_C8_0x02", 0);
      access(0, 1, 0, 8'h02, 8'h00, 8'hC8, 4, "read_0x02", 0);

      // Latch check: address/data change one cycle after sampling.
      @(negedge CLK); #1;
      push(0, 8'hC8, 4, "latch_write_64_0x04");
      drive(0, 1'b0, 1'b1, 8'h04, 8'h64);
      @(posedge CLK); #1;
      drive(0, 1'b0, 1'b1, 8'h05, 8'hFF);
      wait_done(0, "latch_write");
      #1 drive(0, 1'b0, 1'b0, 8'h05, 8'hFF);
      repeat (2) @(negedge CLK);
      access(0, 1, 0, 8'h04, 8'h00, 8'h64, 4, "read_0x04_latched", 0);
      access(0, 1, 0, 8'h05, 8'h00, 8'h00, 4, "read_0x05_untouched", 0);

      // Simultaneous read+write: write wins, readdata untouched.
      access(0, 1, 0, 8'h02, 8'h00, 8'hC8, 4, "read_0x02_again", 0);
      access(0, 1, 1, 8'h07, 8'h21, 8'hC8, 4, "rd_wr_0x07", 0);
      access(0, 1, 0, 8'h07, 8'h00, 8'h21, 4, "read_0x07", 0);

      // Reset in the second ACCESS cycle of a write to 0x09.
      @(negedge CLK); #1;
      push(0, 8'h00, 2, "abort_write_55_0x09");
      drive(0, 1'b0, 1'b1, 8'h09, 8'h55);
      repeat (2) @(negedge CLK);
      #1 RESET = 1'b1;
      drive(0, 1'b0, 1'b0, 8'h09, 8'h55);
      #1 check("abort busy_wait", int'(if4.busy_wait), 0);
      repeat (2) @(negedge CLK);
      #1 RESET = 1'b0;
      access(0, 1, 0, 8'h09, 8'h00, 8'h00, 4, "read_0x09_after_abort", 0);

      // LATENCY=1 build, request held through DONE.
      access(1, 0, 1, 8'h02, 8'h33, 8'h00, 1, "write_33_0x02", 1);
      access(1, 1, 0, 8'h02, 8'h00, 8'h33, 1, "read_0x02_held", 1);
      access(1, 1, 0, 8'h02, 8'h00, 8'h33, 1, "read_0x02_held_again", 1);
      repeat (6) @(negedge CLK);

      check("L4 scoreboard_drained", q4.size(), 0);
      check("L1 scoreboard_drained", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
